mem_bus_arbiter: RTL and testbench

// Shares the single external memory bus between instruction fetch (IF) and data access (MEM).

---
 rtl/cpu_defines.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defines.sv
// Shared definitions for the CPU memory-bus logic.
// Contents: bus width constants, stall-vector bit indices, and the state
// encoding of the memory bus arbiter FSM.
package cpu_defines;

    localparam int unsigned BUS_AW  = 32;
    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned BUS_SW  = BUS_DW / 8;
    localparam int unsigned STALL_W = 6;

    // Stall vector bit positions
    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_MEM = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_BUS   = 3'd1,
        MEM_BUS  = 3'd2,
        IF_DROP  = 3'd3,
        MEM_DROP = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one external bus between instruction fetch (IF)
// and data access (MEM). MEM has fixed priority over IF. Returned words are
// held until the owning pipeline register advances (stall vector low).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall_i, flush_i         pipeline stall vector and flush
//   if_ce_i, if_addr_i       IF read request / word address
//   if_rdata_o               fetched word
//   if_stall_req_o           IF request pending and unserved
//   mem_ce_i, mem_we_i,      MEM request, write enable, byte enables,
//   mem_sel_i, mem_addr_i,   address and write data
//   mem_wdata_i
//   mem_rdata_o              read data
//   mem_stall_req_o          MEM request pending and unserved
//   bus_cyc_o, bus_stb_o,    registered bus master outputs
//   bus_we_o, bus_sel_o,
//   bus_adr_o, bus_dat_o
//   bus_dat_i, bus_ack_i     slave read data and acknowledge
//   bus_err_o                one-cycle pulse when a transfer times out
module mem_bus_arbiter
    import cpu_defines::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               if_ce_i,
    input  logic [BUS_AW-1:0]  if_addr_i,
    output logic [BUS_DW-1:0]  if_rdata_o,
    output logic               if_stall_req_o,
    input  logic               mem_ce_i,
    input  logic               mem_we_i,
    input  logic [BUS_SW-1:0]  mem_sel_i,
    input  logic [BUS_AW-1:0]  mem_addr_i,
    input  logic [BUS_DW-1:0]  mem_wdata_i,
    output logic [BUS_DW-1:0]  mem_rdata_o,
    output logic               mem_stall_req_o,
    output logic               bus_cyc_o,
    output logic               bus_stb_o,
    output logic               bus_we_o,
    output logic [BUS_SW-1:0]  bus_sel_o,
    output logic [BUS_AW-1:0]  bus_adr_o,
    output logic [BUS_DW-1:0]  bus_dat_o,
    input  logic [BUS_DW-1:0]  bus_dat_i,
    input  logic               bus_ack_i,
    output logic               bus_err_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e        state_q, state_d;
    logic              if_vld_q, mem_vld_q;
    logic [CntW-1:0]   tcnt_q;

    logic              if_pend, mem_pend;
    logic              timeout_hit, xfer_done;
    logic              grant_if, grant_mem;
    logic              if_deliver, mem_deliver;
    logic [BUS_DW-1:0] rd_word;
    logic              unused_stall;

    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[STALL_PC]};

    assign if_pend         = if_ce_i & ~if_vld_q;
    assign mem_pend        = mem_ce_i & ~mem_vld_q;
    assign if_stall_req_o  = if_pend;
    assign mem_stall_req_o = mem_pend;
    assign bus_stb_o       = bus_cyc_o;

    // A simultaneous ack wins over the timeout, so no error is flagged.
    assign timeout_hit = (TIMEOUT != 0) && bus_cyc_o && !bus_ack_i &&
                         (tcnt_q == CntW'(TIMEOUT - 1));
    assign xfer_done   = bus_cyc_o && (bus_ack_i || timeout_hit);
    // Timed-out reads return zero.
    assign rd_word     = bus_ack_i ? bus_dat_i : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;
        if_deliver  = 1'b0;
        mem_deliver = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_pend) begin
                    state_d   = MEM_BUS;
                    grant_mem = 1'b1;
                end else if (if_pend) begin
                    state_d  = IF_BUS;
                    grant_if = 1'b1;
                end
            end
            IF_BUS: begin
                if (xfer_done) begin
                    state_d    = IDLE;
                    if_deliver = ~flush_i;
                end else if (flush_i) begin
                    state_d = IF_DROP;
                end
            end
            MEM_BUS: begin
                if (xfer_done) begin
                    state_d     = IDLE;
                    mem_deliver = ~flush_i;
                end else if (flush_i) begin
                    state_d = MEM_DROP;
                end
            end
            IF_DROP, MEM_DROP: begin
                if (xfer_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus master registers and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_cyc_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= '0;
            bus_adr_o <= '0;
            bus_dat_o <= '0;
            bus_err_o <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            bus_err_o <= timeout_hit;
            if (grant_mem) begin
                bus_cyc_o <= 1'b1;
                bus_we_o  <= mem_we_i;
                bus_sel_o <= mem_sel_i;
                bus_adr_o <= mem_addr_i;
                bus_dat_o <= mem_wdata_i;
            end else if (grant_if) begin
                bus_cyc_o <= 1'b1;
                bus_we_o  <= 1'b0;
                bus_sel_o <= '1;
                bus_adr_o <= if_addr_i;
                bus_dat_o <= '0;
            end else if (xfer_done) begin
                bus_cyc_o <= 1'b0;
                bus_we_o  <= 1'b0;
            end
            if (xfer_done) begin
                tcnt_q <= '0;
            end else if (bus_cyc_o) begin
                tcnt_q <= tcnt_q + CntW'(1);
            end
        end
    end

    // Returned words and their valid flags; a flush discards them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_vld_q    <= 1'b0;
            mem_vld_q   <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
        end else begin
            if (flush_i) begin
                if_vld_q <= 1'b0;
            end else if (if_deliver) begin
                if_vld_q <= 1'b1;
            end else if (if_vld_q && !stall_i[STALL_IF]) begin
                if_vld_q <= 1'b0;
            end
            if (if_deliver) begin
                if_rdata_o <= rd_word;
            end

            if (flush_i) begin
                mem_vld_q <= 1'b0;
            end else if (mem_deliver) begin
                mem_vld_q <= 1'b1;
            end else if (mem_vld_q && !stall_i[STALL_MEM]) begin
                mem_vld_q <= 1'b0;
            end
            if (mem_deliver && !bus_we_o) begin
                mem_rdata_o <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import cpu_defines::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_stall_req_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_req_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_stall_req_o (if_stall_req_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_stall_req_o(mem_stall_req_o),
        .bus_cyc_o      (bus_cyc_o),
        .bus_stb_o      (bus_stb_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_adr_o      (bus_adr_o),
        .bus_dat_o      (bus_dat_o),
        .bus_dat_i      (bus_dat_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_o      (bus_err_o)
    );

    // Expected bus transaction; len = cycles cyc stays high (-1: abandoned).
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          len;
        bit          tmo;
    } bus_exp_t;

    // Slave behaviour per transaction; waits < 0 means never ack.
    typedef struct {
        int          waits;
        logic [31:0] data;
    } slv_t;

    bus_exp_t    bus_q[$];
    slv_t        slave_q[$];
    logic [31:0] if_res_q[$];
    logic [31:0] mem_res_q[$];
    logic [31:0] model_mem_rdata;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int len_of(input int w);
        return (w < 0) ? int'(TIMEOUT) : w + 1;
    endfunction

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 3));
        if (r == 6) return int'(TIMEOUT) - 1;
        if (r == 7) return -1;
        return 0;
    endfunction

    // Bus slave: acks after the planned number of wait states; random acks while idle.
    initial begin
        int   k;
        bit   active;
        slv_t cur;
        bus_ack_i = 1'b0;
        bus_dat_i = '0;
        active    = 1'b0;
        k         = 0;
        cur       = '{waits: 0, data: 32'h0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                active    = 1'b0;
                k         = 0;
                bus_ack_i = 1'b0;
            end else if (bus_cyc_o) begin
                if (!active) begin
                    active = 1'b1;
                    k      = 0;
                    if (slave_q.size() > 0) begin
                        cur = slave_q.pop_front();
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL slave_unexpected_cycle: got cyc=1 expected no transaction");
                        cur = '{waits: 0, data: 32'hDEAD_BEEF};
                    end
                end
                bus_ack_i = (cur.waits >= 0) && (k == cur.waits);
                bus_dat_i = bus_ack_i ? cur.data : $urandom;
                k++;
            end else begin
                active    = 1'b0;
                bus_ack_i = ($urandom_range(0, 7) == 0);
                bus_dat_i = $urandom;
            end
        end
    end

    // Monitor: checks each bus transaction and each returned word against the queues.
    initial begin
        bit          prev_cyc;
        bit          if_wait;
        bit          mem_wait;
        int          len;
        bus_exp_t    cur;
        logic [31:0] e;
        prev_cyc = 1'b0;
        if_wait  = 1'b0;
        mem_wait = 1'b0;
        len      = 0;
        cur      = '{adr: 0, we: 0, sel: 0, dat: 0, len: -1, tmo: 0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_cyc = 1'b0;
                len      = 0;
                continue;
            end
            check32("stb_eq_cyc", {31'h0, bus_stb_o}, {31'h0, bus_cyc_o});
            if (bus_cyc_o && !prev_cyc) begin
                len = 0;
                if (bus_q.size() > 0) begin
                    cur = bus_q.pop_front();
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got cyc=1 adr=%h expected idle bus", bus_adr_o);
                    cur = '{adr: bus_adr_o, we: bus_we_o, sel: bus_sel_o, dat: bus_dat_o,
                            len: -1, tmo: 0};
                end
            end
            if (bus_cyc_o) begin
                len++;
                check32("bus_adr", bus_adr_o, cur.adr);
                check32("bus_we", {31'h0, bus_we_o}, {31'h0, cur.we});
                check32("bus_sel", {28'h0, bus_sel_o}, {28'h0, cur.sel});
                if (cur.we) check32("bus_dat", bus_dat_o, cur.dat);
                check32("bus_err_in_cycle", {31'h0, bus_err_o}, 32'h0);
            end else if (prev_cyc) begin
                if (cur.len >= 0) check32("cyc_length", len, cur.len);
                check32("bus_err_pulse", {31'h0, bus_err_o}, {31'h0, cur.tmo});
            end else begin
                check32("bus_err_idle", {31'h0, bus_err_o}, 32'h0);
            end
            prev_cyc = bus_cyc_o;

            if (if_stall_req_o) begin
                if_wait = 1'b1;
            end else if (if_wait) begin
                if_wait = 1'b0;
                if (if_res_q.size() > 0) begin
                    e = if_res_q.pop_front();
                    check32("if_rdata", if_rdata_o, e);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL if_unexpected_return: got %h expected none", if_rdata_o);
                end
            end
            if (mem_stall_req_o) begin
                mem_wait = 1'b1;
            end else if (mem_wait) begin
                mem_wait = 1'b0;
                if (mem_res_q.size() > 0) begin
                    e = mem_res_q.pop_front();
                    check32("mem_rdata", mem_rdata_o, e);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected_return: got %h expected none", mem_rdata_o);
                end
            end
        end
    end

    // Wait until neither side is stalled; returns cycles waited (bounded).
    task automatic wait_served(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((if_stall_req_o || mem_stall_req_o) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL serve_timeout: got stall after %0d cycles expected release", n);
        end
    endtask

    task automatic consume();
        if_ce_i  = 1'b0;
        mem_ce_i = 1'b0;
        stall_i  = 6'($urandom) & 6'b101101;
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 2)) begin
            stall_i = 6'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_scenario(input bit do_if, input bit do_mem, input bit we,
                                input logic [31:0] ia, input logic [31:0] ma,
                                input logic [3:0] sel, input logic [31:0] wd,
                                input int w_if, input int w_mem,
                                input logic [31:0] d_if, input logic [31:0] d_mem);
        int n;
        int exp_n;
        if (do_mem) begin
            bus_q.push_back('{adr: ma, we: we, sel: sel, dat: wd, len: len_of(w_mem),
                              tmo: (w_mem < 0)});
            slave_q.push_back('{waits: w_mem, data: d_mem});
            if (!we) model_mem_rdata = (w_mem < 0) ? 32'h0 : d_mem;
            mem_res_q.push_back(model_mem_rdata);
        end
        if (do_if) begin
            bus_q.push_back('{adr: ia, we: 1'b0, sel: 4'hF, dat: 32'h0, len: len_of(w_if),
                              tmo: (w_if < 0)});
            slave_q.push_back('{waits: w_if, data: d_if});
            if_res_q.push_back((w_if < 0) ? 32'h0 : d_if);
        end
        // One grant cycle, the cycle(s) on the bus, plus one idle cycle between two grants.
        if (do_if && do_mem) exp_n = len_of(w_mem) + len_of(w_if) + 2;
        else if (do_mem)     exp_n = len_of(w_mem) + 1;
        else                 exp_n = len_of(w_if) + 1;

        @(posedge clk);
        #1;
        stall_i     = 6'($urandom) | 6'b010010;
        if_ce_i     = do_if;
        if_addr_i   = ia;
        mem_ce_i    = do_mem;
        mem_we_i    = we;
        mem_addr_i  = ma;
        mem_sel_i   = sel;
        mem_wdata_i = wd;
        wait_served(n);
        check32("stall_cycles", n, exp_n);
        consume();
    endtask

    initial begin
        int n;
        rst         = 1'b0;
        stall_i     = '0;
        flush_i     = 1'b0;
        if_ce_i     = 1'b0;
        if_addr_i   = '0;
        mem_ce_i    = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = '0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        model_mem_rdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check32("rst_cyc", {31'h0, bus_cyc_o}, 32'h0);
        check32("rst_we", {31'h0, bus_we_o}, 32'h0);
        check32("rst_sel", {28'h0, bus_sel_o}, 32'h0);
        check32("rst_adr", bus_adr_o, 32'h0);
        check32("rst_dat", bus_dat_o, 32'h0);
        check32("rst_err", {31'h0, bus_err_o}, 32'h0);
        check32("rst_if_rdata", if_rdata_o, 32'h0);
        check32("rst_mem_rdata", mem_rdata_o, 32'h0);
        #1;
        rst = 1'b1;

        // IF-only zero-wait fetch
        run_scenario(1, 0, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 0, 0, 32'h2402_0005, 32'h0);
        // IF and MEM together: MEM first
        run_scenario(1, 1, 0, 32'h0000_0044, 32'h0000_0300, 4'hF, 32'h0, 0, 1,
                     32'h1111_2222, 32'h3333_4444);
        // MEM write leaves mem_rdata unchanged
        run_scenario(0, 1, 1, 32'h0, 32'h0000_0100, 4'b0011, 32'h0000_ABCD, 0, 1, 32'h0,
                     32'h5555_6666);
        // MEM read timeout
        run_scenario(0, 1, 0, 32'h0, 32'h0000_0500, 4'hF, 32'h0, 0, -1, 32'h0, 32'h7777_8888);
        // Ack coincides with the last timeout cycle
        run_scenario(1, 0, 0, 32'h0000_0048, 32'h0, 4'h0, 32'h0, int'(TIMEOUT) - 1, 0,
                     32'h9999_AAAA, 32'h0);

        for (int i = 0; i < 50; i++) begin
            bit do_if;
            bit do_mem;
            int sel_kind;
            sel_kind = int'($urandom_range(0, 2));
            do_if    = (sel_kind != 1);
            do_mem   = (sel_kind != 0);
            run_scenario(do_if, do_mem, 1'($urandom), {$urandom, 2'b00} & 32'h0000_FFFC,
                         $urandom, 4'($urandom), $urandom, rand_wait(), rand_wait(),
                         $urandom, $urandom);
        end

        // Flush during IF_BUS with 3 wait states; refetch from new address
        bus_q.push_back('{adr: 32'h0000_0800, we: 1'b0, sel: 4'hF, dat: 32'h0, len: 4, tmo: 0});
        slave_q.push_back('{waits: 3, data: 32'hBAD0_BAD0});
        bus_q.push_back('{adr: 32'h0000_0900, we: 1'b0, sel: 4'hF, dat: 32'h0, len: 1, tmo: 0});
        slave_q.push_back('{waits: 0, data: 32'h600D_F00D});
        if_res_q.push_back(32'h600D_F00D);
        @(posedge clk);
        #1;
        stall_i   = 6'b010010;
        if_ce_i   = 1'b1;
        if_addr_i = 32'h0000_0800;
        @(posedge clk);
        #1;
        flush_i   = 1'b1;
        if_addr_i = 32'h0000_0900;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check32("flush_stall_held", {31'h0, if_stall_req_o}, 32'h1);
        wait_served(n);
        check32("flush_stall_cycles", n + 2, 7);
        consume();

        // Reset in the middle of an unacked MEM read
        bus_q.push_back('{adr: 32'h0000_0200, we: 1'b0, sel: 4'hF, dat: 32'h0, len: -1, tmo: 0});
        slave_q.push_back('{waits: -1, data: 32'h0});
        bus_q.push_back('{adr: 32'h0000_0200, we: 1'b0, sel: 4'hF, dat: 32'h0, len: 1, tmo: 0});
        slave_q.push_back('{waits: 0, data: 32'hC0DE_0200});
        mem_res_q.push_back(32'hC0DE_0200);
        @(posedge clk);
        #1;
        stall_i    = 6'b010010;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h0000_0200;
        repeat (3) @(posedge clk);
        #2;
        check32("pre_reset_cyc", {31'h0, bus_cyc_o}, 32'h1);
        rst = 1'b0;
        #1;
        check32("async_rst_cyc", {31'h0, bus_cyc_o}, 32'h0);
        check32("async_rst_stb", {31'h0, bus_stb_o}, 32'h0);
        check32("async_rst_adr", bus_adr_o, 32'h0);
        check32("async_rst_sel", {28'h0, bus_sel_o}, 32'h0);
        check32("async_rst_mem_rdata", mem_rdata_o, 32'h0);
        check32("async_rst_mem_stall", {31'h0, mem_stall_req_o}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        wait_served(n);
        check32("post_reset_regrant_cycles", n, 2);
        consume();

        repeat (5) @(posedge clk);
        #1;
        check32("bus_q_drained", bus_q.size(), 0);
        check32("slave_q_drained", slave_q.size(), 0);
        check32("if_res_q_drained", if_res_q.size(), 0);
        check32("mem_res_q_drained", mem_res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
